// File: rtl/projectile_bank.sv
// Bank of NUM_PROJ projectile slots: launch on fire, move up on tick, retire on hit or top edge.
// Optional PROJ_AUTOFIRE_EN: launch on fire level instead of fire rising edge.
module projectile_bank #(
  parameter int NUM_PROJ = 4,
  parameter int COORD_W  = 10,
  parameter int STEP     = 4,
  parameter int Y_START  = 440,
  parameter int Y_TOP    = 8,
  parameter int COOLDOWN = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [COORD_W-1:0]            ship_xcoord,
  input  logic                          db_fire,
  input  logic                          hit_valid,
  input  logic [2:0]                    hit_idx,
  output logic [NUM_PROJ-1:0]           proj_active,
  output logic [NUM_PROJ*COORD_W-1:0]   proj_xcoord,
  output logic [NUM_PROJ*COORD_W-1:0]   proj_ycoord,
  output logic                          fire_accepted,
  output logic                          slots_full
);

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [COORD_W-1:0] STEP_C     = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] Y_START_C  = COORD_W'(Y_START);
  localparam logic [COORD_W-1:0] MOVE_MIN   = COORD_W'(Y_TOP + STEP);
  localparam logic [CD_W-1:0]    COOLDOWN_C = CD_W'(COOLDOWN);

  logic [COORD_W-1:0] x_q [NUM_PROJ];
  logic [COORD_W-1:0] y_q [NUM_PROJ];
  logic [NUM_PROJ-1:0] active_q;
  logic [CD_W-1:0]     cooldown_q;
  logic                fire_prev;
  logic                armed;
  logic                launch_req;
  logic                free_found;
  logic [2:0]          free_idx;
  logic                accept;

  // armed blocks a fire level held across reset release from counting as an edge
`ifdef PROJ_AUTOFIRE_EN
  assign launch_req = db_fire;
`else
  assign launch_req = db_fire & ~fire_prev & armed;
`endif

  always_comb begin
    free_found = 1'b0;
    free_idx   = 3'd0;
    for (int i = NUM_PROJ - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  assign accept = launch_req & free_found & (cooldown_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q      <= '0;
      cooldown_q    <= '0;
      fire_prev     <= 1'b0;
      armed         <= 1'b0;
      fire_accepted <= 1'b0;
      for (int i = 0; i < NUM_PROJ; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      fire_prev     <= db_fire;
      fire_accepted <= accept;
      if (!db_fire) armed <= 1'b1;

      if (accept)
        cooldown_q <= COOLDOWN_C;
      else if (tick && cooldown_q != '0)
        cooldown_q <= cooldown_q - 1'b1;

      // launch wins on a free slot; hit outranks movement on a live one
      for (int i = 0; i < NUM_PROJ; i++) begin
        if (accept && free_idx == 3'(i)) begin
          active_q[i] <= 1'b1;
          x_q[i]      <= ship_xcoord;
          y_q[i]      <= Y_START_C;
        end else if (active_q[i]) begin
          if (hit_valid && hit_idx == 3'(i)) begin
            active_q[i] <= 1'b0;
            x_q[i]      <= '0;
            y_q[i]      <= '0;
          end else if (tick) begin
            if (y_q[i] >= MOVE_MIN) begin
              y_q[i] <= y_q[i] - STEP_C;
            end else begin
              active_q[i] <= 1'b0;
              x_q[i]      <= '0;
              y_q[i]      <= '0;
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PROJ; g++) begin : g_pack
    assign proj_xcoord[g*COORD_W +: COORD_W] = x_q[g];
    assign proj_ycoord[g*COORD_W +: COORD_W] = y_q[g];
  end

  assign proj_active = active_q;
  assign slots_full  = &active_q;

endmodule
